// File: rtl/cdc_edge_event_b.sv
// rtl/cdc_edge_event_b.sv - clk_b consumer: synchroniser, glitch filter, edge events on a valid/ready slot
module cdc_edge_event_b #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8,
    parameter int RISE_EN     = 1,
    parameter int FALL_EN     = 1
) (
    input  logic             clk_b,
    input  logic             rst_b_n,
    input  logic             in_async,
    input  logic             evt_ready,
    input  logic             clr_overflow,
    output logic             evt_valid,
    output logic             evt_rise,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             level_b,
    output logic             overflow
);

    localparam int FCW = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);

    localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] ST_QUAL_HIGH   = 2'd1;
    localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] ST_QUAL_LOW    = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [FCW-1:0]         r_filt_cnt;
    logic                   r_level;
    logic [CNT_W-1:0]       r_evt_seq;
    logic                   r_evt_valid;
    logic                   r_evt_rise;
    logic [CNT_W-1:0]       r_evt_cnt;
    logic                   r_overflow;

    logic                   w_sync_out;
    logic                   w_differs;
    logic [1:0]             w_state_nxt;
    logic [FCW-1:0]         w_cnt_nxt;
    logic [FCW-1:0]         w_cnt_inc;
    logic                   w_toggle;
    logic                   w_evt;
    logic                   w_xfer;
    logic                   w_drop;
    logic [CNT_W-1:0]       w_seq_nxt;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_differs  = w_sync_out ^ r_level;
    assign w_cnt_inc  = r_filt_cnt + 1'b1;

    // Plain flop chain; nothing may sit between stages
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_async};
        end
    end

    // Qualification FSM: a change must persist FILT_CYCLES samples before level_b follows
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_filt_cnt;
        w_toggle    = 1'b0;
        case (r_state)
            ST_STABLE_LOW, ST_STABLE_HIGH: begin
                if (w_differs) begin
                    if (FILT_CYCLES == 1) begin
                        w_toggle    = 1'b1;
                        w_state_nxt = r_level ? ST_STABLE_LOW : ST_STABLE_HIGH;
                    end else begin
                        w_state_nxt = r_level ? ST_QUAL_LOW : ST_QUAL_HIGH;
                        w_cnt_nxt   = FCW'(1);
                    end
                end
            end
            ST_QUAL_HIGH, ST_QUAL_LOW: begin
                if (w_differs) begin
                    if (w_cnt_inc == FCW'(FILT_CYCLES)) begin
                        w_toggle    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_level ? ST_STABLE_LOW : ST_STABLE_HIGH;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_level ? ST_STABLE_HIGH : ST_STABLE_LOW;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE_LOW;
            end
        endcase
    end

    // Filter state, counter and the accepted level
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_state    <= ST_STABLE_LOW;
            r_filt_cnt <= '0;
            r_level    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_filt_cnt <= w_cnt_nxt;
            if (w_toggle) begin
                r_level <= ~r_level;
            end
        end
    end

    // An event is a toggle toward a level whose edge type is enabled
    assign w_evt     = w_toggle && (r_level ? (FALL_EN != 0) : (RISE_EN != 0));
    assign w_xfer    = r_evt_valid && evt_ready;
    assign w_drop    = w_evt && r_evt_valid && !evt_ready;
    assign w_seq_nxt = r_evt_seq + 1'b1;

    // Sequence counter advances even for dropped events so gaps show up in evt_cnt
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_evt_seq <= '0;
        end else if (w_evt) begin
            r_evt_seq <= w_seq_nxt;
        end
    end

    // Single-entry output slot; a slot draining this edge can take a new event
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_evt_valid <= 1'b0;
            r_evt_rise  <= 1'b0;
            r_evt_cnt   <= '0;
        end else if (w_evt && (!r_evt_valid || evt_ready)) begin
            r_evt_valid <= 1'b1;
            r_evt_rise  <= ~r_level;
            r_evt_cnt   <= w_seq_nxt;
        end else if (w_xfer) begin
            r_evt_valid <= 1'b0;
        end
    end

    // Sticky drop flag; a drop on the same edge as a clear keeps it set
    always_ff @(posedge clk_b or negedge rst_b_n) begin
        if (!rst_b_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_rise  = r_evt_rise;
    assign evt_cnt   = r_evt_cnt;
    assign level_b   = r_level;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_cdc_edge_event_b.sv
// tb/tb_cdc_edge_event_b.sv - directed self-checking bench for cdc_edge_event_b
module tb_cdc_edge_event_b;

    logic       clk_b = 1'b0;
    logic       rst_b_n = 1'b0;

    logic       in_a = 1'b0;
    logic       rdy_a = 1'b0;
    logic       clr_a = 1'b0;
    logic       valid_a, rise_a, level_a, ovf_a;
    logic [7:0] cnt_a;

    logic       in_b = 1'b0;
    logic       rdy_b = 1'b0;
    logic       clr_b = 1'b0;
    logic       valid_b, rise_b, level_b2, ovf_b;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk_b = ~clk_b;

    cdc_edge_event_b u_dut_a (
        .clk_b        (clk_b),
        .rst_b_n      (rst_b_n),
        .in_async     (in_a),
        .evt_ready    (rdy_a),
        .clr_overflow (clr_a),
        .evt_valid    (valid_a),
        .evt_rise     (rise_a),
        .evt_cnt      (cnt_a),
        .level_b      (level_a),
        .overflow     (ovf_a)
    );

    cdc_edge_event_b #(
        .CNT_W   (2),
        .FALL_EN (0)
    ) u_dut_b (
        .clk_b        (clk_b),
        .rst_b_n      (rst_b_n),
        .in_async     (in_b),
        .evt_ready    (rdy_b),
        .clr_overflow (clr_b),
        .evt_valid    (valid_b),
        .evt_rise     (rise_b),
        .evt_cnt      (cnt_b),
        .level_b      (level_b2),
        .overflow     (ovf_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_b);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_b_n = 1'b0;
        step(2);
        rst_b_n = 1'b1;
    endtask

    task automatic chk_a(input string tag, input int lv, input int vl, input int rs, input int ct, input int ov);
        chk({tag, ".level"}, int'(level_a), lv);
        chk({tag, ".valid"}, int'(valid_a), vl);
        chk({tag, ".rise"},  int'(rise_a),  rs);
        chk({tag, ".cnt"},   int'(cnt_a),   ct);
        chk({tag, ".ovf"},   int'(ovf_a),   ov);
    endtask

    int exp_b [5] = '{1, 2, 3, 0, 1};

    initial begin
        // reset state
        step(2);
        chk_a("rst_a", 0, 0, 0, 0, 0);
        chk("rst_b.valid", int'(valid_b), 0);
        chk("rst_b.level", int'(level_b2), 0);
        rst_b_n = 1'b1;
        step(3);

        // basic latency: change before edge k, level follows after edge k+5
        in_a = 1'b1;
        step(5);
        chk_a("lat_pre", 0, 0, 0, 0, 0);
        step(1);
        chk_a("lat_post", 1, 1, 1, 1, 0);
        rdy_a = 1'b1;
        step(1);
        chk("lat_accept.valid", int'(valid_a), 0);
        rdy_a = 1'b0;

        // glitch rejection
        in_a = 1'b0;
        do_reset();
        step(3);
        in_a = 1'b1;
        step(3);
        in_a = 1'b0;
        step(10);
        chk_a("glitch3", 0, 0, 0, 0, 0);
        in_a = 1'b1;
        step(4);
        in_a = 1'b0;
        step(2);
        chk_a("glitch4_rise", 1, 1, 1, 1, 0);
        rdy_a = 1'b1;
        step(1);
        chk("glitch4_acc.valid", int'(valid_a), 0);
        rdy_a = 1'b0;
        step(2);
        chk("glitch4_hold.level", int'(level_a), 1);
        step(1);
        chk_a("glitch4_fall", 0, 1, 0, 2, 0);

        // back-pressure
        do_reset();
        step(3);
        in_a = 1'b1;
        step(8);
        chk_a("bp_ev1", 1, 1, 1, 1, 0);
        in_a = 1'b0;
        step(8);
        chk_a("bp_ev2", 0, 1, 1, 1, 1);
        in_a = 1'b1;
        step(8);
        chk_a("bp_ev3", 1, 1, 1, 1, 1);
        rdy_a = 1'b1;
        step(1);
        rdy_a = 1'b0;
        chk("bp_drain.valid", int'(valid_a), 0);
        in_a = 1'b0;
        step(8);
        chk_a("bp_ev4", 0, 1, 0, 4, 1);

        // clear overflow, then accept and new event on the same edge
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk("clr.ovf", int'(ovf_a), 0);
        in_a = 1'b1;
        step(5);
        rdy_a = 1'b1;
        step(1);
        rdy_a = 1'b0;
        chk_a("simul", 1, 1, 1, 5, 0);

        // drop and clear on the same edge: set wins
        in_a = 1'b0;
        step(5);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk_a("set_vs_clr", 0, 1, 1, 5, 1);
        clr_a = 1'b1;
        step(1);
        clr_a = 1'b0;
        chk("clr2.ovf", int'(ovf_a), 0);

        // asynchronous reset while an event is pending
        rst_b_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0, 0, 0);
        in_a = 1'b1;
        step(2);
        rst_b_n = 1'b1;
        step(5);
        chk("rel_pre.level", int'(level_a), 0);
        step(1);
        chk_a("rel_rise", 1, 1, 1, 1, 0);

        // CNT_W=2, FALL_EN=0: rising events only, counter wraps
        for (int i = 0; i < 5; i++) begin
            in_b = 1'b1;
            step(6);
            chk($sformatf("wrap%0d.level", i), int'(level_b2), 1);
            chk($sformatf("wrap%0d.valid", i), int'(valid_b), 1);
            chk($sformatf("wrap%0d.rise", i), int'(rise_b), 1);
            chk($sformatf("wrap%0d.cnt", i), int'(cnt_b), exp_b[i]);
            rdy_b = 1'b1;
            step(1);
            rdy_b = 1'b0;
            chk($sformatf("wrap%0d.acc", i), int'(valid_b), 0);
            in_b = 1'b0;
            step(6);
            chk($sformatf("wrap%0d.low", i), int'(level_b2), 0);
            chk($sformatf("wrap%0d.nofall", i), int'(valid_b), 0);
        end
        chk("wrap.ovf", int'(ovf_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
